// File: rtl/tree_multiplier.sv
// Signed WIDTH x WIDTH multiplier: radix-4 Booth partial products, carry-save
// reduction tree, one carry-propagate adder, registered product and valid flag.
module tree_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   z,
  output logic                 out_valid
);

  localparam int PW    = 2 * WIDTH;
  localparam int NPP   = WIDTH / 2;
  localparam int NROWS = NPP + 1;

  // Number of rows left after lvl layers of 3:2 compression.
  function automatic int rows_at(input int lvl);
    int n;
    n = NROWS;
    for (int k = 0; k < lvl; k++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int num_levels();
    int n;
    int l;
    n = NROWS;
    l = 0;
    for (int k = 0; k < 64; k++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + (n % 3);
        l++;
      end
    end
    return l;
  endfunction

  localparam int LEVELS = num_levels();

  logic [PW-1:0]  w_a_ext;
  logic [WIDTH:0] w_b_ext;
  logic [PW-1:0]  w_row [LEVELS+1][NROWS];
  logic [PW-1:0]  w_corr;
  logic [NPP-1:0] w_neg;
  logic [PW-1:0]  w_sum;
  logic [PW-1:0]  r_z;
  logic           r_valid;

  assign w_a_ext = {{WIDTH{A[WIDTH-1]}}, A};
  assign w_b_ext = {B, 1'b0};

  genvar gi, gj, gk;

  // Each Booth row is fully sign-extended and inverted when negative; the
  // matching +1 for every negated row is collected in one correction row.
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_booth
      logic [2:0]    w_bits;
      logic          w_one;
      logic          w_two;
      logic [PW-1:0] w_mag;
      logic [PW-1:0] w_sel;
      assign w_bits    = w_b_ext[2*gi+2 : 2*gi];
      assign w_one     = w_bits[1] ^ w_bits[0];
      assign w_two     = (w_bits[2] & ~w_bits[1] & ~w_bits[0]) |
                         (~w_bits[2] & w_bits[1] & w_bits[0]);
      assign w_neg[gi] = w_bits[2];
      assign w_mag     = w_one ? w_a_ext : (w_two ? {w_a_ext[PW-2:0], 1'b0} : '0);
      assign w_sel     = w_neg[gi] ? ~w_mag : w_mag;
      assign w_row[0][gi] = w_sel << (2 * gi);
    end
  endgenerate

  always_comb begin
    w_corr = '0;
    for (int i = 0; i < NPP; i++) begin
      w_corr[2*i] = w_neg[i];
    end
  end

  assign w_row[0][NPP] = w_corr;

  // Wallace layers: groups of three rows become sum/carry pairs, leftovers
  // pass straight through; the carry's bit above PW-1 falls off the top.
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      localparam int N = rows_at(gi);
      localparam int T = N / 3;
      localparam int R = N % 3;
      for (gj = 0; gj < T; gj++) begin : g_csa
        logic [PW-1:0] w_x;
        logic [PW-1:0] w_y;
        logic [PW-1:0] w_c;
        logic [PW-1:0] w_maj;
        assign w_x   = w_row[gi][3*gj];
        assign w_y   = w_row[gi][3*gj+1];
        assign w_c   = w_row[gi][3*gj+2];
        assign w_maj = (w_x & w_y) | (w_x & w_c) | (w_y & w_c);
        assign w_row[gi+1][2*gj]   = w_x ^ w_y ^ w_c;
        assign w_row[gi+1][2*gj+1] = {w_maj[PW-2:0], 1'b0};
      end
      for (gk = 2*T; gk < NROWS; gk++) begin : g_pass
        if (gk < 2*T + R) begin : g_keep
          assign w_row[gi+1][gk] = w_row[gi][3*T + gk - 2*T];
        end else begin : g_zero
          assign w_row[gi+1][gk] = '0;
        end
      end
    end
  endgenerate

  assign w_sum = w_row[LEVELS][0] + w_row[LEVELS][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_z <= w_sum;
      end
    end
  end

  assign z         = r_z;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_tree_multiplier.sv
// Directed-vector and random-stream bench for tree_multiplier.
module tb_tree_multiplier;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] z;
  logic        out_valid;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [10];

  tree_multiplier #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .z         (z),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] exp_z, input logic exp_v);
    checks++;
    if (z !== exp_z || out_valid !== exp_v) begin
      failures++;
      $display("FAIL %s: z=%016h out_valid=%0b, required z=%016h out_valid=%0b",
               name, z, out_valid, exp_z, exp_v);
    end else begin
      $display("ok   %s: z=%016h out_valid=%0b", name, z, out_valid);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rexp;
    logic [63:0] last;
    int          rand_fail;

    checks   = 0;
    failures = 0;

    vecs[0] = '{32'h00000010, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF0, "pos*neg"};
    vecs[1] = '{32'h00000010, 32'h00000020, 64'h0000000000000200, "pos*pos"};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000010, 64'hFFFFFFFFFFFFFFF0, "neg*pos"};
    vecs[3] = '{32'h00000000, 32'h12345678, 64'h0000000000000000, "zero"};
    vecs[4] = '{32'h00000001, 32'h12345678, 64'h0000000012345678, "identity"};
    vecs[5] = '{32'hABCDEF00, 32'h12345678, 64'hFA03443242D20800, "mixed1"};
    vecs[6] = '{32'h76543210, 32'hFEDCBA98, 64'hFF795E36541D5980, "mixed2"};
    vecs[7] = '{32'h80000000, 32'h80000000, 64'h4000000000000000, "minneg*minneg"};
    vecs[8] = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000, "maxpos*minneg"};
    vecs[9] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001, "maxpos*maxpos"};

    // Reset with a valid pair present: the pair must be dropped.
    rst = 1'b1; in_valid = 1'b1; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
    step();
    check("reset_cycle1", 64'h0, 1'b0);
    step();
    check("reset_cycle2", 64'h0, 1'b0);
    rst = 1'b0;
    step();
    check("neg1*neg1_after_reset", 64'h1, 1'b1);

    // Directed vectors, back to back.
    for (int i = 0; i < 10; i++) begin
      A = vecs[i].a;
      B = vecs[i].b;
      in_valid = 1'b1;
      step();
      check(vecs[i].name, vecs[i].exp, 1'b1);
    end

    // Random stream; one summarised comparison per pair, FAIL lines on error.
    rand_fail = 0;
    rexp = '0;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rexp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
      A = ra; B = rb; in_valid = 1'b1;
      step();
      checks++;
      if (z !== rexp || out_valid !== 1'b1) begin
        failures++;
        rand_fail++;
        if (rand_fail <= 10)
          $display("FAIL random[%0d] %08h*%08h: z=%016h out_valid=%0b, required z=%016h out_valid=1",
                   i, ra, rb, z, out_valid, rexp);
      end
    end
    $display("random stream: 1000 pairs, %0d mismatching", rand_fail);
    last = rexp;

    // Drop in_valid with new operands on the bus: z must hold.
    in_valid = 1'b0; A = 32'h00000003; B = 32'h00000005;
    step();
    check("hold1", last, 1'b0);
    step();
    check("hold2", last, 1'b0);

    // Mid-stream reset discards the pair presented with it.
    in_valid = 1'b1; A = 32'h00000007; B = 32'hFFFFFFFD;
    step();
    check("pre_reset", 64'hFFFFFFFFFFFFFFEB, 1'b1);
    rst = 1'b1; A = 32'h00001000; B = 32'h00001000;
    step();
    check("midstream_reset", 64'h0, 1'b0);
    rst = 1'b0; A = 32'h00001000; B = 32'h00001000;
    step();
    check("resume", 64'h0000000001000000, 1'b1);
    in_valid = 1'b0;
    step();
    check("resume_hold", 64'h0000000001000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
